// File: rtl/platform_scheduler.sv
// Platform scheduler: turns camera advance into scroll pulses and paces
// pseudo-random platform spawns through a req/ack handshake.
module platform_scheduler #(
  parameter int unsigned SCROLL_STEP = 16,
  parameter int unsigned MIN_GAP     = 48,
  parameter int unsigned Y_BASE      = 300,
  parameter int unsigned Y_SPAN_LOG2 = 7,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [9:0] camera_pos,
  input  logic       mem_ack,
  output logic       advance,
  output logic       create_platform,
  output logic [8:0] location,
  output logic [7:0] spawn_count,
  output logic       timeout_err
);

  localparam int unsigned CAM_W  = 10;
  localparam int unsigned PEND_W = 11;
  localparam int unsigned GAP_W  = 9;
  localparam int unsigned TMO_W  = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [15:0] SEED   = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [PEND_W:0] PEND_MAX = (PEND_W + 1)'(1023);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADV  = 2'd1;
  localparam logic [1:0] PICK = 2'd2;
  localparam logic [1:0] REQ  = 2'd3;

  logic [1:0]        state, next_state;
  logic [CAM_W-1:0]  last_cam;
  logic [PEND_W-1:0] pending, pending_n, cam_add;
  logic [PEND_W:0]   pend_sum;
  logic [GAP_W-1:0]  gap_ctr, gap_adv, next_gap, next_spawn_gap;
  logic [15:0]       lfsr, lfsr_n;
  logic [TMO_W-1:0]  tmo_ctr;
  logic              tmo_done;

  // Datapath helpers shared by the next-state logic and the registers
  always_comb begin
    cam_add  = (camera_pos > last_cam) ? PEND_W'(camera_pos - last_cam) : '0;
    pend_sum = (PEND_W + 1)'(pending) + (PEND_W + 1)'(cam_add)
             - ((state == ADV) ? (PEND_W + 1)'(SCROLL_STEP) : '0);
    pending_n = (pend_sum > PEND_MAX) ? PEND_MAX[PEND_W-1:0] : pend_sum[PEND_W-1:0];
    gap_adv  = gap_ctr + GAP_W'(SCROLL_STEP);
    lfsr_n   = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    tmo_done = (tmo_ctr == TMO_W'(ACK_TIMEOUT - 1));
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (enable && pending >= PEND_W'(SCROLL_STEP)) next_state = ADV;
      ADV:  next_state = (gap_adv >= next_gap) ? PICK : IDLE;
      PICK: next_state = REQ;
      REQ:  if (mem_ack || tmo_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Outputs are registered from the next state so they align with it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      advance         <= 1'b0;
      create_platform <= 1'b0;
      location        <= '0;
      spawn_count     <= '0;
      timeout_err     <= 1'b0;
      last_cam        <= '0;
      pending         <= '0;
      gap_ctr         <= '0;
      next_gap        <= GAP_W'(MIN_GAP);
      next_spawn_gap  <= GAP_W'(MIN_GAP);
      lfsr            <= SEED;
      tmo_ctr         <= '0;
    end else begin
      advance         <= (next_state == ADV);
      create_platform <= (next_state == REQ);
      last_cam        <= camera_pos;
      pending         <= pending_n;
      case (state)
        ADV: gap_ctr <= gap_adv;
        PICK: begin
          lfsr           <= lfsr_n;
          location       <= GAP_W'(Y_BASE) + GAP_W'(lfsr_n[Y_SPAN_LOG2-1:0]);
          next_spawn_gap <= GAP_W'(MIN_GAP) + GAP_W'(lfsr_n[15:10]);
          tmo_ctr        <= '0;
        end
        REQ: begin
          if (mem_ack) begin
            spawn_count <= spawn_count + 8'd1;
            gap_ctr     <= gap_ctr - next_gap;
            next_gap    <= next_spawn_gap;
          end else if (tmo_done) begin
            timeout_err <= 1'b1;
            gap_ctr     <= '0;
            next_gap    <= next_spawn_gap;
          end else begin
            tmo_ctr <= tmo_ctr + TMO_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_platform_scheduler.sv
// Directed bench for platform_scheduler: scroll pulses, spawns, timeout,
// resync, async reset and pending saturation.
module tb_platform_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [9:0] camera_pos;
  logic       mem_ack;
  logic       advance;
  logic       create_platform;
  logic [8:0] location;
  logic [7:0] spawn_count;
  logic       timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Observation counters, written only by the monitor below
  int adv_total = 0;
  int cre_total = 0;
  int b2b_total = 0;
  int cyc       = 0;
  int last_adv  = -100;
  int adv_space = 0;
  int last_loc  = 0;
  logic prev_adv = 1'b0;

  int a0, c0;

  platform_scheduler dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .camera_pos      (camera_pos),
    .mem_ack         (mem_ack),
    .advance         (advance),
    .create_platform (create_platform),
    .location        (location),
    .spawn_count     (spawn_count),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (advance) begin
      adv_total = adv_total + 1;
      adv_space = cyc - last_adv;
      last_adv  = cyc;
      if (prev_adv) b2b_total = b2b_total + 1;
    end
    if (create_platform) begin
      cre_total = cre_total + 1;
      last_loc  = int'(location);
    end
    prev_adv = advance;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    camera_pos = 10'd0;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; camera_pos = 10'd0; mem_ack = 1'b1;
    tick(2);
    check("rst_advance", int'(advance), 0);
    check("rst_create", int'(create_platform), 0);
    check("rst_location", int'(location), 0);
    check("rst_spawn", int'(spawn_count), 0);
    check("rst_timeout", int'(timeout_err), 0);
    reset = 1'b0;
    tick(1);

    // 1: 48 px -> three pulses, then one accepted spawn at row 412
    a0 = adv_total; c0 = cre_total;
    camera_pos = 10'd48;
    tick(20);
    check("t1_adv_count", adv_total - a0, 3);
    check("t1_adv_space", adv_space, 2);
    check("t1_create_cycles", cre_total - c0, 1);
    check("t1_location", last_loc, 412);
    check("t1_spawn", int'(spawn_count), 1);
    check("t1_create_low", int'(create_platform), 0);
    camera_pos = 10'd63;
    tick(10);
    check("t1_pending_zero", adv_total - a0, 3);

    // 2: no ack -> request held 255 cycles then abandoned
    mem_ack = 1'b0;
    do_reset();
    a0 = adv_total; c0 = cre_total;
    camera_pos = 10'd48;
    tick(300);
    check("t2_create_cycles", cre_total - c0, 255);
    check("t2_location", last_loc, 412);
    check("t2_create_low", int'(create_platform), 0);
    check("t2_timeout", int'(timeout_err), 1);
    check("t2_spawn", int'(spawn_count), 0);
    tick(20);
    check("t2_timeout_sticky", int'(timeout_err), 1);

    // 3: accumulate while disabled, then drain 6 pulses leaving 4
    mem_ack = 1'b1;
    enable  = 1'b0;
    do_reset();
    a0 = adv_total;
    camera_pos = 10'd100;
    tick(20);
    check("t3_disabled_adv", adv_total - a0, 0);
    enable = 1'b1;
    tick(60);
    check("t3_adv_count", adv_total - a0, 6);
    check("t3_spawn", int'(spawn_count), 1);
    camera_pos = 10'd111;
    tick(10);
    check("t3_pending15_idle", adv_total - a0, 6);
    camera_pos = 10'd112;
    tick(10);
    check("t3_pending16_adv", adv_total - a0, 7);

    // 4: backward camera resyncs without touching pending
    do_reset();
    a0 = adv_total;
    camera_pos = 10'd200;
    tick(80);
    check("t4_adv_count", adv_total - a0, 12);
    check("t4_spawn", int'(spawn_count), 2);
    check("t4_location2", last_loc, 356);
    camera_pos = 10'd50;
    tick(20);
    check("t4_resync_adv", adv_total - a0, 12);
    camera_pos = 10'd66;
    tick(20);
    check("t4_one_more_adv", adv_total - a0, 13);

    // 5: async reset in the middle of a request
    mem_ack = 1'b0;
    do_reset();
    camera_pos = 10'd48;
    begin
      int waited;
      waited = 0;
      while (!create_platform && waited < 50) begin
        tick(1);
        waited++;
      end
      check("t5_reach_req", int'(create_platform), 1);
    end
    #2;
    reset = 1'b1;
    #1;
    check("t5_async_create", int'(create_platform), 0);
    check("t5_async_location", int'(location), 0);
    check("t5_async_advance", int'(advance), 0);
    tick(2);
    mem_ack = 1'b1;
    c0 = cre_total;
    reset = 1'b0;
    tick(20);
    check("t5_respawn_count", cre_total - c0, 1);
    check("t5_respawn_loc", last_loc, 412);
    check("t5_spawn", int'(spawn_count), 1);

    // 6: repeated full-range steps saturate pending at 1023
    enable = 1'b0;
    do_reset();
    a0 = adv_total;
    camera_pos = 10'd1023; tick(1);
    camera_pos = 10'd0;    tick(1);
    camera_pos = 10'd1023; tick(1);
    camera_pos = 10'd0;    tick(1);
    camera_pos = 10'd1023; tick(1);
    check("t6_disabled_adv", adv_total - a0, 0);
    enable = 1'b1;
    tick(300);
    check("t6_adv_count", adv_total - a0, 63);
    camera_pos = 10'd0; tick(1);
    camera_pos = 10'd1; tick(10);
    check("t6_residual15", adv_total - a0, 64);

    check("never_back_to_back", b2b_total, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
